// File: rtl/jtag_gpr_access.sv
// Debug-side GPR access sequencer: halts the core, performs one register-file
// read or write through the JTAG port, and returns a valid/ready response.
//
// state  | meaning
// IDLE   | waiting for a command; halt_req follows the held-halt flag
// HALT   | requesting halt, counting cycles without halt_ack
// ACCESS | one-cycle register-file access under halt
// RESP   | response presented until rsp_ready_i
module jtag_gpr_access #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        cmd_keep_halt_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        halt_req_o,
  input  logic        halt_ack_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        held_q, held_d;
  logic        cap_write_q, cap_write_d;
  logic [4:0]  cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic        cap_keep_q, cap_keep_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        halt_req_q, halt_req_d;
  logic        we_arm_q, we_arm_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    cap_write_d = cap_write_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_keep_d  = cap_keep_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cap_write_d = cmd_write_i;
          cap_addr_d  = cmd_addr_i;
          cap_wdata_d = cmd_wdata_i;
          cap_keep_d  = cmd_keep_halt_i;
          if (held_q && halt_ack_i) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_HALT;
            cnt_d   = '0;
          end
        end
      end
      ST_HALT: begin
        if (halt_ack_i) begin
          state_d = ST_ACCESS;
        end else if (cnt_inc == 17'(HALT_TIMEOUT)) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          held_d      = 1'b0;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_err_d   = !halt_ack_i;
        rsp_rdata_d = (!cap_write_q && halt_ack_i) ? reg_rdata_i : 32'd0;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          held_d      = cap_keep_q && !rsp_err_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    halt_req_d  = (state_d == ST_IDLE) ? held_d : 1'b1;
    we_arm_d    = (state_d == ST_ACCESS) && cap_write_d && (cap_addr_d != 5'd0);
    if (state_d == ST_ACCESS) begin
      reg_addr_d = cap_addr_d;
      if (cap_write_d) begin
        reg_wdata_d = cap_wdata_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_keep_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      halt_req_q  <= 1'b0;
      we_arm_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      cap_write_q <= cap_write_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_keep_q  <= cap_keep_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      halt_req_q  <= halt_req_d;
      we_arm_q    <= we_arm_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign halt_req_o  = halt_req_q;
  // Halt lost inside ACCESS must block the write in that same cycle.
  assign reg_we_o    = we_arm_q && halt_ack_i;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_jtag_gpr_access.sv
// Directed bench for jtag_gpr_access with a small register-file model.
module tb_jtag_gpr_access;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        cmd_keep_halt_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        halt_req_o;
  logic        halt_ack_i;
  logic        reg_we_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [4:0]  we_addr;
  logic [31:0] we_data;
  logic [31:0] rf [32];

  jtag_gpr_access #(.HALT_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_keep_halt_i(cmd_keep_halt_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .halt_req_o(halt_req_o), .halt_ack_i(halt_ack_i),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_init(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  assign reg_rdata_i = (reg_addr_o == 5'd0) ? 32'd0 : rf[reg_addr_o];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
      we_addr <= '0;
      we_data <= '0;
    end else if (reg_we_o) begin
      we_cnt          <= we_cnt + 1;
      we_addr         <= reg_addr_o;
      we_data         <= reg_wdata_o;
      rf[reg_addr_o]  <= reg_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accept edge, with cmd_valid_i dropped.
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic k);
    int guard;
    guard = 0;
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a;
    cmd_wdata_i = d; cmd_keep_halt_i = k;
    while (!cmd_ready_o && guard < 20) begin
      step();
      guard++;
    end
    check("cmd_ready_before_accept", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Latency in cycles from the accept edge to the first rsp_valid_o cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake(input logic exp_halt);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid_o), 32'd0);
    check("cmd_ready_after_hs", 32'(cmd_ready_o), 32'd1);
    check("halt_req_after_hs", 32'(halt_req_o), 32'(exp_halt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int we_before;
    logic bad;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_keep_halt_i = 1'b0; rsp_ready_i = 1'b0; halt_ack_i = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_halt_req", 32'(halt_req_o), 32'd0);
    check("rst_reg_we", 32'(reg_we_o), 32'd0);
    check("rst_reg_addr", 32'(reg_addr_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    rst = 1'b0;
    step();
    check("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

    // Write x5, ack first seen in cycle T+3.
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    check("t1_halt_req", 32'(halt_req_o), 32'd1);
    check("t1_cmd_ready", 32'(cmd_ready_o), 32'd0);
    step();
    step();
    halt_ack_i = 1'b1;
    step();
    check("t1_reg_we", 32'(reg_we_o), 32'd1);
    check("t1_reg_addr", 32'(reg_addr_o), 32'd5);
    check("t1_reg_wdata", reg_wdata_o, 32'hDEADBEEF);
    check("t1_rsp_valid_early", 32'(rsp_valid_o), 32'd0);
    step();
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("t1_rsp_err", 32'(rsp_err_o), 32'd0);
    check("t1_rsp_rdata", rsp_rdata_o, 32'd0);
    check("t1_we_cnt", 32'(we_cnt), 32'd1);
    check("t1_we_addr", 32'(we_addr), 32'd5);
    check("t1_we_data", we_data, 32'hDEADBEEF);
    check("t1_reg_we_resp", 32'(reg_we_o), 32'd0);
    check("t1_reg_addr_hold", 32'(reg_addr_o), 32'd5);
    handshake(1'b0);

    // Read x5 back, keep_halt=0.
    issue(1'b0, 5'd5, 32'd0, 1'b0);
    wait_rsp(lat);
    check("t1r_latency", 32'(lat), 32'd3);
    check("t1r_rdata", rsp_rdata_o, 32'hDEADBEEF);
    check("t1r_err", 32'(rsp_err_o), 32'd0);
    check("t1r_halt_in_resp", 32'(halt_req_o), 32'd1);
    handshake(1'b0);

    // x0: write suppressed, read returns 0.
    we_before = we_cnt;
    issue(1'b1, 5'd0, 32'h12345678, 1'b0);
    wait_rsp(lat);
    check("t2_latency", 32'(lat), 32'd3);
    check("t2_err", 32'(rsp_err_o), 32'd0);
    check("t2_we_cnt", 32'(we_cnt), 32'(we_before));
    handshake(1'b0);
    issue(1'b0, 5'd0, 32'd0, 1'b0);
    wait_rsp(lat);
    check("t2r_rdata", rsp_rdata_o, 32'd0);
    check("t2r_err", 32'(rsp_err_o), 32'd0);
    handshake(1'b0);

    // Halt timeout with keep_halt=1: error and held flag cleared.
    halt_ack_i = 1'b0;
    we_before = we_cnt;
    issue(1'b0, 5'd3, 32'd0, 1'b1);
    wait_rsp(lat);
    check("t3_latency", 32'(lat), 32'd9);
    check("t3_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("t3_err", 32'(rsp_err_o), 32'd1);
    check("t3_rdata", rsp_rdata_o, 32'd0);
    check("t3_halt_in_resp", 32'(halt_req_o), 32'd1);
    check("t3_we_cnt", 32'(we_cnt), 32'(we_before));
    handshake(1'b0);

    // keep_halt read of x1, then x2 skips HALT.
    halt_ack_i = 1'b1;
    issue(1'b0, 5'd1, 32'd0, 1'b1);
    wait_rsp(lat);
    check("t4a_latency", 32'(lat), 32'd3);
    check("t4a_rdata", rsp_rdata_o, rf_init(1));
    handshake(1'b1);
    issue(1'b0, 5'd2, 32'd0, 1'b0);
    wait_rsp(lat);
    check("t4b_latency", 32'(lat), 32'd2);
    check("t4b_rdata", rsp_rdata_o, rf_init(2));
    check("t4b_err", 32'(rsp_err_o), 32'd0);
    handshake(1'b0);

    // Response stalled for 5 cycles.
    issue(1'b0, 5'd7, 32'd0, 1'b0);
    wait_rsp(lat);
    check("t5_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("t5_rdata", rsp_rdata_o, rf_init(7));
      check("t5_err", 32'(rsp_err_o), 32'd0);
      check("t5_cmd_ready", 32'(cmd_ready_o), 32'd0);
      step();
    end
    handshake(1'b0);

    // Halt lost during ACCESS of a keep_halt write.
    we_before = we_cnt;
    issue(1'b1, 5'd9, 32'hCAFEF00D, 1'b1);
    step();
    halt_ack_i = 1'b0;
    #1;
    check("t6_reg_we_suppressed", 32'(reg_we_o), 32'd0);
    step();
    check("t6_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("t6_err", 32'(rsp_err_o), 32'd1);
    check("t6_rdata", rsp_rdata_o, 32'd0);
    check("t6_we_cnt", 32'(we_cnt), 32'(we_before));
    check("t6_rf9", rf[9], rf_init(9));
    handshake(1'b0);

    // Reset while in HALT.
    issue(1'b1, 5'd10, 32'h0BADF00D, 1'b0);
    check("t7_halt_req", 32'(halt_req_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("t7_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("t7_halt_req_rst", 32'(halt_req_o), 32'd0);
    check("t7_reg_we", 32'(reg_we_o), 32'd0);
    check("t7_reg_addr", 32'(reg_addr_o), 32'd0);
    check("t7_reg_wdata", reg_wdata_o, 32'd0);
    step();
    check("t7_cmd_ready_after", 32'(cmd_ready_o), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid_o || reg_we_o || halt_req_o) bad = 1'b1;
      step();
    end
    check("t7_no_activity", 32'(bad), 32'd0);
    check("t7_we_cnt", 32'(we_cnt), 32'(we_before));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
